// File: rtl/ot_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ot_uart_tx_arbiter
//
// Shares one ot_uart transmitter between NUM_REQ on-chip requesters. A
// round-robin arbiter picks one pending word, the sequencer issues the
// single-cycle write strobe and then follows Tx_busy through the whole frame
// before the transmitter can be granted again.
//
// Optional feature (compile-time macro UART_ARB_ID_HDR_EN):
//   When defined, every grant sends a header word first ({1, 0.., grant_id})
//   and then the data word. done pulses only after the data word; a timeout
//   on the header drops the data word.
//
// Ports:
//   clk_50m      in   single clock, rising edge
//   clear        in   synchronous active-high reset
//   req_valid    in   [NUM_REQ]            per-requester word pending
//   req_data     in   [NUM_REQ*DATA_BITS]  requester i at [i*DATA_BITS +: DATA_BITS]
//   req_ready    out  [NUM_REQ]            one-cycle accept pulse (one-hot or zero)
//   tx_data_in   out  [DATA_BITS]          to ot_uart data_in
//   tx_wr_en     out                       to ot_uart wr_en (single-cycle pulse)
//   tx_busy      in                        from ot_uart Tx_busy
//   grant_id     out  [ID_W]               current or most recent grant
//   active       out                       grant until completion or timeout
//   done         out                       one-cycle frame-complete pulse
//   err_timeout  out                       one-cycle pulse: tx_busy never rose
//   state_dbg    out  [2]                  sequencer state (IDLE=0, SEND=1,
//                                          WAIT_BUSY=2, WAIT_DONE=3)
//
// Handshake: a requester holds req_valid/req_data stable until it sees its
// req_ready bit for one cycle; that cycle is the accept. Dropping req_valid
// before the accept withdraws the request.
// ---------------------------------------------------------------------------
module ot_uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int BUSY_TIMEOUT = 16,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                           clk_50m,
    input  logic                           clear,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_BITS-1:0]           tx_data_in,
    output logic                           tx_wr_en,
    input  logic                           tx_busy,
    output logic [ID_W-1:0]                grant_id,
    output logic                           active,
    output logic                           done,
    output logic                           err_timeout,
    output logic [1:0]                     state_dbg
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // Registered state and outputs
    state_t                 state_q,      state_n;
    logic [CNT_W-1:0]       cnt_q,        cnt_n;
    logic [ID_W-1:0]        last_grant_q, last_grant_n;
    logic [NUM_REQ-1:0]     req_ready_q,  req_ready_n;
    logic [DATA_BITS-1:0]   tx_data_q,    tx_data_n;
    logic                   tx_wr_en_q,   tx_wr_en_n;
    logic [ID_W-1:0]        grant_id_q,   grant_id_n;
    logic                   active_q,     active_n;
    logic                   done_q,       done_n;
    logic                   err_q,        err_n;

`ifdef UART_ARB_ID_HDR_EN
    // Data word parked while the header frame is on the wire
    logic [DATA_BITS-1:0]   hold_q,       hold_n;
    // Set while the header is in flight and the data word still has to go
    logic                   hdr_phase_q,  hdr_phase_n;
    logic [DATA_BITS-1:0]   hdr_word;
`endif

    // Arbitration results
    logic                   win_found;
    logic [ID_W-1:0]        win_id;
    logic [DATA_BITS-1:0]   win_data;
    logic [CNT_W-1:0]       cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // -----------------------------------------------------------------------
    // Round-robin pick: scan from last_grant+1 upward with wrap-around. The
    // explicit modulo keeps the scan correct for non-power-of-two NUM_REQ.
    // -----------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [ID_W-1:0] idx;
            idx = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    // Winner's word, selected with constant part-selects
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_data = req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

`ifdef UART_ARB_ID_HDR_EN
    always_comb begin
        hdr_word                = '0;
        hdr_word[ID_W-1:0]      = win_id;
        hdr_word[DATA_BITS-1]   = 1'b1;
    end
`endif

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        last_grant_n = last_grant_q;
        req_ready_n  = '0;
        tx_wr_en_n   = 1'b0;
        tx_data_n    = tx_data_q;
        grant_id_n   = grant_id_q;
        active_n     = active_q;
        done_n       = 1'b0;
        err_n        = 1'b0;
`ifdef UART_ARB_ID_HDR_EN
        hold_n       = hold_q;
        hdr_phase_n  = hdr_phase_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // The tx_busy gate also protects a frame left in flight by a
                // mid-frame clear.
                if (!tx_busy && win_found) begin
                    grant_id_n = win_id;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        req_ready_n[i] = (win_id == ID_W'(i));
                    end
                    active_n   = 1'b1;
                    tx_wr_en_n = 1'b1;
`ifdef UART_ARB_ID_HDR_EN
                    tx_data_n   = hdr_word;
                    hold_n      = win_data;
                    hdr_phase_n = 1'b1;
`else
                    tx_data_n   = win_data;
`endif
                    state_n    = ST_SEND;
                end
            end

            // The strobe is visible for exactly this one cycle
            ST_SEND: begin
                cnt_n   = '0;
                state_n = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = ST_WAIT_DONE;
                end else if (cnt_inc == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never took the word: drop it and move on
                    err_n        = 1'b1;
                    active_n     = 1'b0;
                    last_grant_n = grant_id_q;
                    state_n      = ST_IDLE;
`ifdef UART_ARB_ID_HDR_EN
                    hdr_phase_n  = 1'b0;
`endif
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            ST_WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef UART_ARB_ID_HDR_EN
                    if (hdr_phase_q) begin
                        // Header is on the wire; strobe the parked data word
                        tx_wr_en_n  = 1'b1;
                        tx_data_n   = hold_q;
                        hdr_phase_n = 1'b0;
                        state_n     = ST_SEND;
                    end else begin
                        done_n       = 1'b1;
                        active_n     = 1'b0;
                        last_grant_n = grant_id_q;
                        state_n      = ST_IDLE;
                    end
`else
                    done_n       = 1'b1;
                    active_n     = 1'b0;
                    last_grant_n = grant_id_q;
                    state_n      = ST_IDLE;
`endif
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_50m) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            // First grant after reset goes to requester 0
            last_grant_q <= ID_W'(NUM_REQ - 1);
            req_ready_q  <= '0;
            tx_data_q    <= '0;
            tx_wr_en_q   <= 1'b0;
            grant_id_q   <= '0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef UART_ARB_ID_HDR_EN
            hold_q       <= '0;
            hdr_phase_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            last_grant_q <= last_grant_n;
            req_ready_q  <= req_ready_n;
            tx_data_q    <= tx_data_n;
            tx_wr_en_q   <= tx_wr_en_n;
            grant_id_q   <= grant_id_n;
            active_q     <= active_n;
            done_q       <= done_n;
            err_q        <= err_n;
`ifdef UART_ARB_ID_HDR_EN
            hold_q       <= hold_n;
            hdr_phase_q  <= hdr_phase_n;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_data_in  = tx_data_q;
    assign tx_wr_en    = tx_wr_en_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ot_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ot_uart_tx_arbiter
//
// Bench for ot_uart_tx_arbiter with a behavioural ot_uart busy model
// (Tx_busy rises the cycle after the strobe and stays high BUSY_LEN cycles).
// Expected strobes {req_ready, grant_id, word} are queued when stimulus is
// driven and compared when tx_wr_en is seen. Honours UART_ARB_ID_HDR_EN.
// ---------------------------------------------------------------------------
module tb_ot_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int DATA_BITS    = 8;
  localparam int BUSY_TIMEOUT = 16;
  localparam int ID_W         = 2;
  localparam int BUSY_LEN     = 20;
  localparam int EW           = NUM_REQ + ID_W + DATA_BITS;

  // ---------------- clock / reset ----------------
  logic clk_50m = 1'b0;
  logic clear   = 1'b1;
  always #10 clk_50m = ~clk_50m;

  logic [NUM_REQ-1:0]           req_valid = '0;
  logic [NUM_REQ*DATA_BITS-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]           req_ready;
  logic [DATA_BITS-1:0]         tx_data_in;
  logic                         tx_wr_en;
  logic                         tx_busy = 1'b0;
  logic [ID_W-1:0]              grant_id;
  logic                         active;
  logic                         done;
  logic                         err_timeout;
  logic [1:0]                   state_dbg;

  ot_uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_BITS    (DATA_BITS),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk_50m     (clk_50m),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data_in  (tx_data_in),
    .tx_wr_en    (tx_wr_en),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .done        (done),
    .err_timeout (err_timeout),
    .state_dbg   (state_dbg)
  );

  // ---------------- behavioural ot_uart busy model ----------------
  bit         busy_en   = 1'b0;
  logic [4:0] busy_left = '0;

  always @(posedge clk_50m) begin
    if (busy_en && tx_wr_en && !tx_busy) begin
      tx_busy   <= 1'b1;
      busy_left <= 5'(BUSY_LEN - 1);
    end else if (tx_busy) begin
      if (busy_left == 0) tx_busy <= 1'b0;
      else                busy_left <= busy_left - 5'd1;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int checks     = 0;
  int errors     = 0;
  int cyc        = 0;
  int strobes    = 0;
  int done_cnt   = 0;
  int to_cnt     = 0;
  int strobe_cyc = 0;
  logic busy_d   = 1'b0;
  logic busy_dd  = 1'b0;
  bit auto_drop  = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk_50m);
    // Requesters withdraw a word once they see their accept pulse
    if (auto_drop) req_valid = req_valid & ~req_ready;
  endtask

  task automatic set_req(input int id, input logic [DATA_BITS-1:0] data);
    req_data[id*DATA_BITS +: DATA_BITS] = data;
    req_valid[id] = 1'b1;
  endtask

  // full=0: the grant ends before the data word (timeout/clear in header mode)
  task automatic push_grant(input int id, input logic [DATA_BITS-1:0] data, input bit full);
    logic [NUM_REQ-1:0] rdy;
    logic [ID_W-1:0]    gid;
    rdy = '0;
    rdy[id] = 1'b1;
    gid = ID_W'(id);
`ifdef UART_ARB_ID_HDR_EN
    exp_q.push_back({rdy, gid, 8'h80 | 8'(id)});
    if (full) exp_q.push_back({{NUM_REQ{1'b0}}, gid, data});
`else
    if (full || !full) exp_q.push_back({rdy, gid, data});
`endif
  endtask

  function automatic logic [DATA_BITS-1:0] first_word(input int id, input logic [DATA_BITS-1:0] data);
`ifdef UART_ARB_ID_HDR_EN
    return 8'h80 | 8'(id);
`else
    return data;
`endif
  endfunction

  task automatic wait_strobes(input int target, input int budget);
    int n = 0;
    while (strobes < target && n < budget) begin
      step();
      n++;
    end
    check_eq("strobe_wait", 32'(strobes >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(req_valid == '0 && state_dbg == 2'd0 && !tx_busy && !active) && n < budget) begin
      step();
      n++;
    end
    check_eq("idle_wait", 32'(n < budget), 1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_50m) begin
    logic [EW-1:0] e;
    cyc++;
    if (tx_wr_en) begin
      strobes++;
      strobe_cyc = cyc;
      check_eq("no_overlap", tx_busy, 0);
      check_eq("strobe_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("tx_data_in", tx_data_in, e[DATA_BITS-1:0]);
        check_eq("grant_id", grant_id, e[DATA_BITS +: ID_W]);
        check_eq("req_ready", req_ready, e[DATA_BITS+ID_W +: NUM_REQ]);
      end
    end else if (req_ready != '0) begin
      check_eq("stray_ready", req_ready, 0);
    end
    if (done) begin
      done_cnt++;
      check_eq("done_after_fall", {busy_dd, busy_d}, 2'b10);
    end
    if (err_timeout) begin
      to_cnt++;
      check_eq("timeout_latency", cyc - strobe_cyc, BUSY_TIMEOUT);
    end
    busy_dd = busy_d;
    busy_d  = tx_busy;
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    int d0;
    int n;

    // Reset values
    clear = 1'b1;
    repeat (3) step();
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_tx_wr_en", tx_wr_en, 0);
    check_eq("rst_active", active, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err_timeout, 0);
    check_eq("rst_tx_data", tx_data_in, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_state", state_dbg, 0);
    clear = 1'b0;
    step();

    // Single request from requester 1
    busy_en = 1'b1;
    set_req(1, 8'h5A);
    push_grant(1, 8'h5A, 1'b1);
    step();
    check_eq("t1_req_ready", req_ready, 4'b0010);
    check_eq("t1_wr_en", tx_wr_en, 1);
    check_eq("t1_active", active, 1);
    check_eq("t1_word", tx_data_in, first_word(1, 8'h5A));
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 200) begin step(); n++; end
    check_eq("t1_done_seen", done_cnt - d0, 1);
    wait_idle(200);

    // All four requesters continuously valid: rotation 0,1,2,3,0
    clear = 1'b1;
    step();
    clear = 1'b0;
    auto_drop = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'h10 + 8'(i));
    for (int i = 0; i < 5; i++) push_grant(i % NUM_REQ, 8'h10 + 8'(i % NUM_REQ), 1'b1);
    s0 = strobes;
`ifdef UART_ARB_ID_HDR_EN
    wait_strobes(s0 + 9, 400);
`else
    wait_strobes(s0 + 5, 400);
`endif
    req_valid = '0;
    auto_drop = 1'b1;
    wait_idle(200);

    // tx_busy stuck low: two timeouts, requester 1 then 2
    busy_en = 1'b0;
    d0 = to_cnt;
    set_req(1, 8'h21);
    set_req(2, 8'h22);
    push_grant(1, 8'h21, 1'b0);
    push_grant(2, 8'h22, 1'b0);
    n = 0;
    while (to_cnt < d0 + 2 && n < 100) begin step(); n++; end
    check_eq("t3_timeouts", to_cnt - d0, 2);
    wait_idle(50);
    check_eq("t3_idle_state", state_dbg, 0);

    // clear during WAIT_DONE while the frame is still on the wire
    busy_en = 1'b1;
    set_req(3, 8'h33);
    push_grant(3, 8'h33, 1'b0);
    n = 0;
    while (state_dbg != 2'd3 && n < 50) begin step(); n++; end
    check_eq("t4_reach_wait_done", state_dbg, 3);
    clear = 1'b1;
    step();
    check_eq("t4_clr_req_ready", req_ready, 0);
    check_eq("t4_clr_wr_en", tx_wr_en, 0);
    check_eq("t4_clr_active", active, 0);
    check_eq("t4_clr_done", done, 0);
    check_eq("t4_clr_err", err_timeout, 0);
    check_eq("t4_clr_tx_data", tx_data_in, 0);
    check_eq("t4_clr_grant_id", grant_id, 0);
    check_eq("t4_clr_state", state_dbg, 0);
    clear = 1'b0;
    set_req(0, 8'h40);
    push_grant(0, 8'h40, 1'b1);
    wait_idle(300);

    // Requester 2 withdraws before its grant; requester 3 is next
    set_req(1, 8'h51);
    push_grant(1, 8'h51, 1'b1);
    s0 = strobes;
    wait_strobes(s0 + 1, 20);
    set_req(2, 8'h52);
    set_req(3, 8'h53);
    repeat (5) step();
    req_valid[2] = 1'b0;
    push_grant(3, 8'h53, 1'b1);
    wait_idle(300);

    // Requester 3 = 0xC4 (header 0x83 first when the header option is on)
    d0 = done_cnt;
    set_req(3, 8'hC4);
    push_grant(3, 8'hC4, 1'b1);
    wait_idle(300);
    check_eq("t6_single_done", done_cnt - d0, 1);

    // Final scoreboard state
    repeat (3) step();
    check_eq("queue_empty", exp_q.size(), 0);
    check_eq("done_total", done_cnt, 10);
    check_eq("timeout_total", to_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
